// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the stream pattern generator: mode encodings,
// LFSR seed/taps and the scheduler state encoding.
package pattern_gen_pkg;

  localparam logic [1:0] PG_MODE_CNT   = 2'd0;
  localparam logic [1:0] PG_MODE_CONST = 2'd1;
  localparam logic [1:0] PG_MODE_LFSR  = 2'd2;

  localparam logic [31:0] PG_LFSR_SEED = 32'hACE1_0001;
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] PG_LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_ARMED = 2'd1,
    PG_SEND  = 2'd2,
    PG_DONE  = 2'd3
  } pg_state_e;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1
  function automatic logic [31:0] pg_lfsr_step(input logic [31:0] s);
    logic [31:0] fb;
    if (s[0]) begin
      fb = PG_LFSR_TAPS;
    end else begin
      fb = 32'h0000_0000;
    end
    return {1'b0, s[31:1]} ^ fb;
  endfunction

endpackage

// File: rtl/pg_lfsr32.sv
// 32-bit Galois LFSR that steps once per adv pulse; exposes both the
// current state and the state it will take on the next step.
module pg_lfsr32
  import pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] state,
  output logic [31:0] state_next
);

  logic [31:0] state_r;

  assign state_next = pg_lfsr_step(state_r);
  assign state      = state_r;

  // Load the seed on reset, otherwise step only when asked
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= seed;
    end else if (adv) begin
      state_r <= state_next;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// Epoch-scheduled test-pattern source: once per epoch emits BURST_LEN samples
// of NUM_CH words each on a valid/ready/last stream, with overrun and
// epoch-overlap reporting.
module stream_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_CH       = 1,
  parameter int SAMPLE_DIV   = 47,
  parameter int BURST_LEN    = 10,
  parameter int EPOCH_CYCLES = 125_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_data,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_ch,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [31:0]       epoch_cnt,
  output logic [15:0]       drop_cnt,
  output logic              overlap_err
);

  localparam logic [3:0]  LAST_CH    = 4'(NUM_CH - 1);
  localparam logic [31:0] LAST_SMP   = 32'(BURST_LEN - 1);
  localparam logic [31:0] EPOCH_LAST = 32'(EPOCH_CYCLES - 1);
  localparam logic [31:0] TICK_LAST  = 32'(SAMPLE_DIV - 1);

  pg_state_e         state_r, state_nxt_s;
  logic [31:0]       epoch_ctr_r, tick_ctr_r;
  logic              epoch_start_s, tick_s, xfer_s;
  logic [1:0]        mode_r, mode_nxt_s;
  logic [31:0]       sample_idx_r, sample_idx_nxt_s;
  logic [DATA_W-1:0] m_data_r, m_data_nxt_s;
  logic [3:0]        m_ch_r, m_ch_nxt_s;
  logic              m_valid_r, m_valid_nxt_s;
  logic              m_last_r, m_last_nxt_s;
  logic [31:0]       epoch_cnt_r, epoch_cnt_nxt_s;
  logic [15:0]       drop_cnt_r, drop_cnt_nxt_s;
  logic              overlap_r, overlap_nxt_s;
  logic              lfsr_adv_s;
  logic [31:0]       lfsr_state_s, lfsr_next_s;

  assign epoch_start_s = (epoch_ctr_r == EPOCH_LAST);
  assign tick_s        = (tick_ctr_r == TICK_LAST);
  assign xfer_s        = m_valid_r & m_ready;

  assign m_data      = m_data_r;
  assign m_ch        = m_ch_r;
  assign m_valid     = m_valid_r;
  assign m_last      = m_last_r;
  assign epoch_cnt   = epoch_cnt_r;
  assign drop_cnt    = drop_cnt_r;
  assign overlap_err = overlap_r;

  // Pattern word for a given channel; constant mode uses const_data live
  function automatic logic [DATA_W-1:0] word_data(
    input logic [1:0]        md,
    input logic [31:0]       idx,
    input logic [3:0]        ch,
    input logic [31:0]       lfsr,
    input logic [DATA_W-1:0] cdata
  );
    logic [31:0] sum;
    sum = idx + {28'd0, ch};
    case (md)
      PG_MODE_CNT:   word_data = sum[DATA_W-1:0];
      PG_MODE_CONST: word_data = cdata;
      PG_MODE_LFSR:  word_data = lfsr[DATA_W-1:0];
      default:       word_data = sum[DATA_W-1:0];
    endcase
  endfunction

  pg_lfsr32 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .seed       (PG_LFSR_SEED),
    .adv        (lfsr_adv_s),
    .state      (lfsr_state_s),
    .state_next (lfsr_next_s)
  );

  // Free-running epoch timer and sample-tick divider (divider realigns each epoch)
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_ctr_r <= 32'd0;
      tick_ctr_r  <= 32'd0;
    end else begin
      if (epoch_start_s) begin
        epoch_ctr_r <= 32'd0;
      end else begin
        epoch_ctr_r <= epoch_ctr_r + 32'd1;
      end
      if (epoch_start_s || tick_s) begin
        tick_ctr_r <= 32'd0;
      end else begin
        tick_ctr_r <= tick_ctr_r + 32'd1;
      end
    end
  end

  // Next-state, next-word and status computation for the burst scheduler
  always_comb begin
    state_nxt_s      = state_r;
    mode_nxt_s       = mode_r;
    sample_idx_nxt_s = sample_idx_r;
    m_valid_nxt_s    = m_valid_r;
    m_data_nxt_s     = m_data_r;
    m_ch_nxt_s       = m_ch_r;
    m_last_nxt_s     = m_last_r;
    epoch_cnt_nxt_s  = epoch_cnt_r;
    drop_cnt_nxt_s   = drop_cnt_r;
    lfsr_adv_s       = 1'b0;

    // Any epoch boundary outside IDLE is ignored but flagged, sticky until reset
    if (epoch_start_s && (state_r != PG_IDLE)) begin
      overlap_nxt_s = 1'b1;
    end else begin
      overlap_nxt_s = overlap_r;
    end

    case (state_r)
      PG_IDLE: begin
        if (epoch_start_s && enable) begin
          state_nxt_s      = PG_ARMED;
          mode_nxt_s       = mode;
          sample_idx_nxt_s = 32'd0;
        end else begin
          state_nxt_s = PG_IDLE;
        end
      end
      PG_ARMED: begin
        if (tick_s) begin
          state_nxt_s   = PG_SEND;
          m_valid_nxt_s = 1'b1;
          m_ch_nxt_s    = 4'd0;
          m_data_nxt_s  = word_data(mode_r, sample_idx_r, 4'd0, lfsr_state_s, const_data);
          m_last_nxt_s  = (LAST_CH == 4'd0) && (sample_idx_r == LAST_SMP);
        end else begin
          state_nxt_s = PG_ARMED;
        end
      end
      PG_SEND: begin
        // A tick while the previous sample is still draining is lost
        if (tick_s) begin
          if (drop_cnt_r == 16'hFFFF) begin
            drop_cnt_nxt_s = drop_cnt_r;
          end else begin
            drop_cnt_nxt_s = drop_cnt_r + 16'd1;
          end
        end else begin
          drop_cnt_nxt_s = drop_cnt_r;
        end
        if (xfer_s) begin
          lfsr_adv_s = (mode_r == PG_MODE_LFSR);
          if (m_ch_r == LAST_CH) begin
            m_valid_nxt_s    = 1'b0;
            m_last_nxt_s     = 1'b0;
            sample_idx_nxt_s = sample_idx_r + 32'd1;
            if (sample_idx_r == LAST_SMP) begin
              state_nxt_s = PG_DONE;
            end else begin
              state_nxt_s = PG_ARMED;
            end
          end else begin
            // Next channel goes out back-to-back; LFSR value is the post-step one
            m_ch_nxt_s   = m_ch_r + 4'd1;
            m_data_nxt_s = word_data(mode_r, sample_idx_r, m_ch_r + 4'd1, lfsr_next_s, const_data);
            m_last_nxt_s = ((m_ch_r + 4'd1) == LAST_CH) && (sample_idx_r == LAST_SMP);
            state_nxt_s  = PG_SEND;
          end
        end else begin
          state_nxt_s = PG_SEND;
        end
      end
      PG_DONE: begin
        state_nxt_s     = PG_IDLE;
        epoch_cnt_nxt_s = epoch_cnt_r + 32'd1;
      end
      default: begin
        state_nxt_s   = PG_IDLE;
        m_valid_nxt_s = 1'b0;
        m_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Scheduler state and registered stream/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= PG_IDLE;
      mode_r       <= PG_MODE_CNT;
      sample_idx_r <= 32'd0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
      m_ch_r       <= 4'd0;
      m_last_r     <= 1'b0;
      epoch_cnt_r  <= 32'd0;
      drop_cnt_r   <= 16'd0;
      overlap_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mode_r       <= mode_nxt_s;
      sample_idx_r <= sample_idx_nxt_s;
      m_valid_r    <= m_valid_nxt_s;
      m_data_r     <= m_data_nxt_s;
      m_ch_r       <= m_ch_nxt_s;
      m_last_r     <= m_last_nxt_s;
      epoch_cnt_r  <= epoch_cnt_nxt_s;
      drop_cnt_r   <= drop_cnt_nxt_s;
      overlap_r    <= overlap_nxt_s;
    end
  end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Self-checking bench for stream_pattern_gen: randomized stimulus against a
// cycle-level behavioural model of the epoch/sample schedule, plus a second
// instance with a short epoch to exercise burst/epoch overlap.
module tb_stream_pattern_gen;

  localparam int E  = 64;
  localparam int D  = 4;
  localparam int B  = 3;
  localparam int NC = 2;

  logic        clk_int;
  logic        rst, enable, m_ready;
  logic [1:0]  mode;
  logic [31:0] const_data, m_data;
  logic [3:0]  m_ch;
  logic        m_valid, m_last, overlap_err;
  logic [31:0] epoch_cnt;
  logic [15:0] drop_cnt;

  logic        rst_ov;
  logic [31:0] ov_data, ov_epoch;
  logic [3:0]  ov_ch;
  logic        ov_valid, ov_last, ov_overlap;
  logic [15:0] ov_drop;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  stream_pattern_gen #(.DATA_W(32), .NUM_CH(NC), .SAMPLE_DIV(D), .BURST_LEN(B), .EPOCH_CYCLES(E)) dut (
    .clk(clk_int), .rst(rst), .enable(enable), .mode(mode), .const_data(const_data),
    .m_data(m_data), .m_ch(m_ch), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .epoch_cnt(epoch_cnt), .drop_cnt(drop_cnt), .overlap_err(overlap_err)
  );

  stream_pattern_gen #(.DATA_W(32), .NUM_CH(NC), .SAMPLE_DIV(D), .BURST_LEN(B), .EPOCH_CYCLES(8)) dut_ov (
    .clk(clk_int), .rst(rst_ov), .enable(1'b1), .mode(2'd0), .const_data(32'd0),
    .m_data(ov_data), .m_ch(ov_ch), .m_valid(ov_valid), .m_last(ov_last), .m_ready(1'b1),
    .epoch_cnt(ov_epoch), .drop_cnt(ov_drop), .overlap_err(ov_overlap)
  );

  initial clk_int = 1'b0;
  always #5 clk_int = ~clk_int;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ecnt, m_tcnt;      // cycles into epoch / into sample period
  bit          m_active;            // burst in progress
  bit          m_done;              // burst just finished, count it next cycle
  bit          m_ovl;
  int          m_epochs, m_drops;
  int          m_smp;               // index of current sample within burst
  logic [1:0]  m_mode;
  logic [31:0] m_lfsr;
  bit          busy;                // a word is on offer
  int          h_ch;
  logic [31:0] h_data;
  bit          h_last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic load_head();
    case (m_mode)
      2'd1:    h_data = const_data;
      2'd2:    h_data = m_lfsr;
      default: h_data = m_smp + h_ch;
    endcase
    h_last = (h_ch == NC - 1) && (m_smp == B - 1);
  endtask

  // Advance the model by one clock edge, using the inputs currently driven
  task automatic model_update();
    bit es, tk;
    if (rst) begin
      m_ecnt = 0; m_tcnt = 0; m_active = 0; m_done = 0; m_ovl = 0;
      m_epochs = 0; m_drops = 0; m_smp = 0; m_mode = 2'd0;
      m_lfsr = 32'hACE1_0001; busy = 0; h_ch = 0; h_data = 0; h_last = 0;
      return;
    end
    es = (m_ecnt == E - 1);
    tk = (m_tcnt == D - 1);
    if (m_done) begin
      m_epochs++;
      m_done = 0;
      if (es) m_ovl = 1;
    end else if (m_active) begin
      if (es) m_ovl = 1;
      if (busy) begin
        if (tk && m_drops < 16'hFFFF) m_drops++;
        if (m_ready) begin
          if (m_mode == 2'd2) m_lfsr = lfsr_step(m_lfsr);
          if (h_ch == NC - 1) begin
            busy = 0;
            m_smp++;
            if (m_smp == B) begin
              m_active = 0;
              m_done   = 1;
            end
          end else begin
            h_ch++;
            load_head();
          end
        end
      end else if (tk) begin
        busy = 1;
        h_ch = 0;
        load_head();
      end
    end else if (es && enable) begin
      m_active = 1;
      m_mode   = mode;
      m_smp    = 0;
    end
    m_tcnt = (es || tk) ? 0 : m_tcnt + 1;
    m_ecnt = es ? 0 : m_ecnt + 1;
  endtask

  task automatic compare_all();
    check_val("m_valid", {31'd0, m_valid}, {31'd0, busy});
    if (busy) begin
      check_val("m_data", m_data, h_data);
      check_val("m_ch", {28'd0, m_ch}, h_ch);
      check_val("m_last", {31'd0, m_last}, {31'd0, h_last});
    end else begin
      check_val("m_last_idle", {31'd0, m_last}, 32'd0);
    end
    check_val("epoch_cnt", epoch_cnt, m_epochs);
    check_val("drop_cnt", {16'd0, drop_cnt}, m_drops);
    check_val("overlap_err", {31'd0, overlap_err}, {31'd0, m_ovl});
  endtask

  task automatic step(input logic r, input logic en, input logic [1:0] md,
                      input logic [31:0] cd, input logic rdy);
    rst = r; enable = en; mode = md; const_data = cd; m_ready = rdy;
    model_update();
    @(negedge clk_int);
    compare_all();
  endtask

  // ---------------- overlap instance monitor ----------------
  int ov_words = 0;
  int ov_lasts = 0;
  always @(negedge clk_int) begin
    if (!rst_ov && ov_valid) begin
      check_val("ov_ch", {28'd0, ov_ch}, ov_words % 2);
      check_val("ov_data", ov_data, (ov_words / 2) + (ov_words % 2));
      check_val("ov_last", {31'd0, ov_last}, (ov_words == 5) ? 32'd1 : 32'd0);
      if (ov_words == 5) begin
        ov_words = 0;
        ov_lasts++;
      end else begin
        ov_words++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, d0, e0;
    logic [31:0] cd;
    rst_ov = 1'b1;
    @(negedge clk_int);
    repeat (4) step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    rst_ov = 1'b0;

    // counter mode, no backpressure
    repeat (90) step(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_val("t1_epochs", epoch_cnt, 32'd1);

    // constant mode
    repeat (64) step(1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 1'b1);
    check_val("t2_drops", {16'd0, drop_cnt}, 32'd0);

    // stall the first word of a burst long enough to lose two ticks
    n = 0;
    while (!busy && n < 200) begin
      step(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
      n++;
    end
    check_val("t3_wait_first_word", {31'd0, busy}, 32'd1);
    d0 = m_drops;
    repeat (9) step(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    repeat (60) step(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_val("t3_drops", {16'd0, drop_cnt}, d0 + 2);

    // LFSR mode, then a full epoch with enable low
    repeat (140) step(1'b0, 1'b1, 2'd2, 32'd0, 1'b1);
    repeat (70) step(1'b0, 1'b0, 2'd2, 32'd0, 1'b1);
    e0 = m_epochs;
    repeat (70) step(1'b0, 1'b0, 2'd2, 32'd0, 1'b1);
    check_val("t5_disabled_epochs", epoch_cnt, e0);

    // reset in the middle of a burst (third word on offer)
    n = 0;
    while (!(busy && m_smp == 1) && n < 200) begin
      step(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
      n++;
    end
    check_val("t6_wait_word3", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b1, 2'd0, 32'd0, 1'b1);
    check_val("t6_valid", {31'd0, m_valid}, 32'd0);
    check_val("t6_last", {31'd0, m_last}, 32'd0);
    check_val("t6_epochs", epoch_cnt, 32'd0);
    check_val("t6_drops", {16'd0, drop_cnt}, 32'd0);
    repeat (90) step(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);

    // random traffic
    cd = $urandom;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) cd = $urandom;
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) != 0),
           2'($urandom_range(0, 3)), cd, ($urandom_range(0, 9) < 7));
    end

    check_val("t4_overlap_err", {31'd0, ov_overlap}, 32'd1);
    check_val("t4_bursts_seen", (ov_lasts >= 3) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
